// File: rtl/heavy_part_ram_arbiter.sv
// rtl/heavy_part_ram_arbiter.sv - heavy-part bucket RAM arbiter for lookup reads and write-back writes
//
// Purpose: shares one single-port bucket RAM between the lookup read stage and
// the compare/update write-back stage. Both request streams are queued; one
// RAM access is granted per cycle with write priority, write bursts are bounded
// while a read waits, and a read is held while any pending write targets the
// same bucket. Read data returns with a valid strobe aligned to RAM latency.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   rd_req, rd_addr, rd_alf         read request stream, read queue almost full
//   wr_req, wr_addr, wr_data, wr_alf  write request stream, write queue almost full
//   ram_addr, ram_rden, ram_wren, ram_wdata  registered RAM command
//   ram_q                           RAM read data (RD_LAT cycles after ram_rden)
//   rd_valid, rd_data               returned read data and its strobe
//   ovf_err                         sticky: a request hit a full queue and was dropped
module heavy_part_ram_arbiter #(
  parameter int DATA_W       = 96,
  parameter int ADDR_W       = 12,
  parameter int QDEPTH       = 8,
  parameter int MAX_WR_BURST = 4,
  parameter int RD_LAT       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_alf,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_alf,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rden,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_q,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              ovf_err
);
  localparam int PW = $clog2(QDEPTH);
  localparam int BW = $clog2(MAX_WR_BURST + 1);
  localparam logic [PW:0]   ALF_LVL   = (PW+1)'(QDEPTH - 2);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_WR_BURST);

  // Read queue: addresses only. Pointers carry one extra bit so full and
  // empty are told apart when the low bits match.
  logic [ADDR_W-1:0] rq_mem [QDEPTH];
  logic [PW:0]       rq_wp, rq_rp, rq_used;
  logic              rq_empty, rq_full, rq_push, rq_pop;
  logic [ADDR_W-1:0] rq_head;

  // Write queue: {addr, data} plus a per-slot valid bit so every pending
  // write address can be compared against the read head.
  logic [ADDR_W-1:0] wq_addr [QDEPTH];
  logic [DATA_W-1:0] wq_data [QDEPTH];
  logic [QDEPTH-1:0] wq_vld;
  logic [PW:0]       wq_wp, wq_rp, wq_used;
  logic              wq_empty, wq_full, wq_push, wq_pop;

  logic              rd_conflict, rd_elig, grant_wr, grant_rd;
  logic [BW-1:0]     wr_burst;
  logic [RD_LAT:0]   vshift;

  assign rq_used  = rq_wp - rq_rp;
  assign rq_empty = (rq_wp == rq_rp);
  assign rq_full  = (rq_wp[PW] != rq_rp[PW]) && (rq_wp[PW-1:0] == rq_rp[PW-1:0]);
  assign rq_head  = rq_mem[rq_rp[PW-1:0]];
  assign rd_alf   = (rq_used >= ALF_LVL);

  assign wq_used  = wq_wp - wq_rp;
  assign wq_empty = (wq_wp == wq_rp);
  assign wq_full  = (wq_wp[PW] != wq_rp[PW]) && (wq_wp[PW-1:0] == wq_rp[PW-1:0]);
  assign wr_alf   = (wq_used >= ALF_LVL);

  assign rq_push  = rd_req && !rq_full;
  assign wq_push  = wr_req && !wq_full;
  assign rq_pop   = grant_rd;
  assign wq_pop   = grant_wr;

  // A read is held while its bucket has any queued write or is being
  // written by the command currently in the RAM register.
  always_comb begin
    rd_conflict = ram_wren && (ram_addr == rq_head);
    for (int i = 0; i < QDEPTH; i++) begin
      if (wq_vld[i] && (wq_addr[i] == rq_head)) begin
        rd_conflict = 1'b1;
      end
    end
  end

  assign rd_elig  = !rq_empty && !rd_conflict;
  assign grant_wr = !wq_empty && (!rd_elig || (wr_burst < BURST_MAX));
  assign grant_rd = !grant_wr && rd_elig;

  // Queue storage needs no reset; only pointers and valid bits do.
  always_ff @(posedge clk) begin
    if (rq_push) begin
      rq_mem[rq_wp[PW-1:0]] <= rd_addr;
    end
    if (wq_push) begin
      wq_addr[wq_wp[PW-1:0]] <= wr_addr;
      wq_data[wq_wp[PW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rq_wp  <= '0;
      rq_rp  <= '0;
      wq_wp  <= '0;
      wq_rp  <= '0;
      wq_vld <= '0;
    end else begin
      if (rq_push) rq_wp <= rq_wp + (PW+1)'(1);
      if (rq_pop)  rq_rp <= rq_rp + (PW+1)'(1);
      if (wq_push) wq_wp <= wq_wp + (PW+1)'(1);
      if (wq_pop)  wq_rp <= wq_rp + (PW+1)'(1);
      // Push and pop never hit the same slot: a full queue refuses the push
      // and an empty queue cannot be popped.
      if (wq_pop)  wq_vld[wq_rp[PW-1:0]] <= 1'b0;
      if (wq_push) wq_vld[wq_wp[PW-1:0]] <= 1'b1;
    end
  end

  // Burst counter only matters while reads are waiting; it restarts on every
  // read grant or whenever the read queue drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_burst <= '0;
    end else if (rq_empty || grant_rd) begin
      wr_burst <= '0;
    end else if (grant_wr && (wr_burst < BURST_MAX)) begin
      wr_burst <= wr_burst + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_rden  <= 1'b0;
      ram_wren  <= 1'b0;
      ram_wdata <= '0;
    end else begin
      ram_wren <= grant_wr;
      ram_rden <= grant_rd;
      if (grant_wr) begin
        ram_addr  <= wq_addr[wq_rp[PW-1:0]];
        ram_wdata <= wq_data[wq_rp[PW-1:0]];
      end else if (grant_rd) begin
        ram_addr <= rq_head;
      end
    end
  end

  // vshift[RD_LAT-1] marks the cycle ram_q holds the requested bucket;
  // vshift[RD_LAT] is the matching rd_valid one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vshift  <= '0;
      rd_data <= '0;
      ovf_err <= 1'b0;
    end else begin
      vshift <= {vshift[RD_LAT-1:0], ram_rden};
      if (vshift[RD_LAT-1]) begin
        rd_data <= ram_q;
      end
      if ((rd_req && rq_full) || (wr_req && wq_full)) begin
        ovf_err <= 1'b1;
      end
    end
  end

  assign rd_valid = vshift[RD_LAT];

endmodule

// File: doc/heavy_part_ram_arbiter.md
# heavy_part_ram_arbiter

Shares one single-port 4096-entry heavy-part bucket RAM between the lookup read stage (read requests carrying a 12-bit bucket index) and the compare/update write-back stage (bucket write requests). It buffers both request streams, grants one RAM access per cycle with write priority, bounds write bursts so reads cannot starve, and holds any read whose address matches a pending write. It also returns read data with a valid strobe aligned to RAM latency. It sits between the table-read stage, the write-back stage and the RAM instance.

## Interface
- DATA_W, 96, bucket entry width: key 32 + positive vote 32 + flag/negative vote 32
- ADDR_W, 12, bucket index width (4096 buckets)
- QDEPTH, 8, depth of each request queue (power of 2)
- MAX_WR_BURST, 4, consecutive write grants allowed while a read is waiting
- RD_LAT, 2, RAM read latency in cycles from registered rden to valid q
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rd_req  in  1  read request strobe; one request per cycle
- rd_addr  in  ADDR_W  bucket index to read
- rd_alf  out  1  read queue almost full, asserted when used >= QDEPTH-2
- wr_req  in  1  write-back request strobe
- wr_addr  in  ADDR_W  bucket index to write
- wr_data  in  DATA_W  bucket contents to write
- wr_alf  out  1  write queue almost full, asserted when used >= QDEPTH-2
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_rden  out  1  RAM read enable (registered)
- ram_wren  out  1  RAM write enable (registered)
- ram_wdata  out  DATA_W  RAM write data (registered)
- ram_q  in  DATA_W  RAM read data
- rd_valid  out  1  read data valid strobe
- rd_data  out  DATA_W  read data, registered copy of ram_q
- ovf_err  out  1  sticky flag: a request was dropped because its queue was full

## Operation
- Two FIFOs of QDEPTH entries each: the read queue holds addresses, the write queue holds {addr, data}. A request is enqueued on the clk edge where its strobe is high and its queue is not full.
- A request that arrives while its queue is full is dropped and sets ovf_err. ovf_err stays set until reset.
- Read head is eligible when the read queue is non-empty and its address differs from every valid write-queue entry and from the write in the ram command register of the current cycle.
- Grant rule, evaluated each cycle:
  - If the write queue is non-empty and either no read is eligible or wr_burst < MAX_WR_BURST, grant the write head.
  - Otherwise, if a read is eligible, grant the read head.
  - Otherwise, grant nothing.
- wr_burst counter:
  - Increments on each write grant made while the read queue is non-empty.
  - Clears on any read grant, and when the read queue is empty.
  - Saturates at MAX_WR_BURST.
- On a grant, the head of the granted queue is popped. The ram_* registers load {addr, wren/rden, data} in the same cycle. When there is no grant, ram_rden=ram_wren=0; ram_addr and ram_wdata hold their values.
- Ordering: reads never bypass an older or same-cycle write to the same address. Writes may pass an older non-conflicting read. Reads stay in order with respect to each other. Writes stay in order with respect to each other.
- A valid shift register of RD_LAT+1 bits carries ram_rden. rd_data loads ram_q when the delayed rden arrives, and rd_valid pulses for one cycle.
- Simultaneous rd_req and wr_req are both enqueued in the same cycle.
- Reset mid-operation: both queues flush, in-flight reads are discarded (no rd_valid), and all outputs go to their reset values.

## Timing
- Reset values: ram_addr=0, ram_rden=0, ram_wren=0, ram_wdata=0, rd_valid=0, rd_data=0, rd_alf=0, wr_alf=0, ovf_err=0, wr_burst=0.
- Request strobe in cycle 0 with an empty queue and no competition gives the RAM command in cycle 2. Cycle 1 is queue head presentation and grant.
- A read command in cycle n gives rd_valid in cycle n+RD_LAT+1.
- Sustained throughput is one RAM access per cycle.
- rd_alf and wr_alf are combinational from the registered queue counts. Two entries of slack cover the upstream one-cycle reaction.
- Queue pointers wrap modulo QDEPTH. Full and empty are distinguished by an extra pointer bit.

## Test plan
- Single read rd_addr=0x123, RD_LAT=2, ram_q model = addr replicated -> ram_rden with ram_addr=0x123 in cycle 2; rd_valid with rd_data=model(0x123) in cycle 5.
- Write 0x0AB/data D, then a read of 0x0AB one cycle later -> ram_wren for 0x0AB precedes ram_rden for 0x0AB; the read returns D from the RAM model.
- Read queue holding reads and 10 back-to-back writes to other addresses -> grant pattern W,W,W,W,R,W,W,W,W,R; no read waits more than MAX_WR_BURST grants.
- 10 back-to-back rd_req with no RAM activity blocking and the write queue held full of a conflicting address -> rd_alf asserts when 6 entries are used; the 9th and 10th requests are dropped; ovf_err=1 and stays 1.
- Same-cycle rd_req(0x010) and wr_req(0x020) on empty queues -> write command in cycle 2 and read command in cycle 3; rd_valid in cycle 6.
- Assert reset while 3 reads are in flight -> no rd_valid after reset; all outputs at reset values; a fresh read after deassertion follows the cycle-2 latency.
